ss_scan_driver: RTL and testbench
=================================

SS_SCAN_DRIVER -- requirements
Module: ss_scan_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000, meaning clock cycles per digit slot (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port enable  input  1  scan-advance enable.
REQ-005 SHALL have port value  input  32  eight hex nibbles to display; nibble k drives digit k.
REQ-006 SHALL have port load  input  1  single-cycle strobe that captures value.
REQ-007 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-008 SHALL have port counter  output  3  current digit index; feeds the anode-select decoder.
REQ-009 SHALL have port seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port tick  output  1  one-cycle pulse on each digit advance.

Function
REQ-011 SHALL keep a 20-bit prescaler counting 0..CLK_DIV-1 while enable=1 and holding while enable=0.
REQ-012 SHALL assert tick for exactly the cycle after the one in which the prescaler equals CLK_DIV-1 with enable=1; prescaler returns to 0 in that same update.
REQ-013 SHALL increment counter modulo 8 in the same update that asserts tick (7 wraps to 0); frame = 8 ticks.
REQ-014 SHALL write value into a 32-bit shadow register and set a pending flag on every cycle with load=1; later loads overwrite earlier ones.
REQ-015 SHALL copy shadow to the 32-bit active register and clear pending only in the update where counter wraps 7->0 and pending=1; no mid-frame change of displayed data.
REQ-016 SHALL, when load=1 coincides with a 7->0 wrap while pending=1, copy the old shadow into active, capture the new value into shadow, and leave pending=1.
REQ-017 SHALL accept loads while enable=0; transfer still waits for a wrap.
REQ-018 SHALL decode seg from active nibble[counter] with hex glyphs 0-9,A,b,C,d,E,F; e.g. 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
REQ-019 SHALL, when blank_lz=1, drive seg=1111111 for every digit index above the highest non-zero nibble of active; digit 0 is never blanked (active=0 shows a single '0').
REQ-020 SHALL derive seg, counter and tick only from registers; no combinational path from any input to any output.

Reset
REQ-021 SHALL, on any clock edge with rst_n=0, clear prescaler, counter, shadow, active, pending and tick to 0, regardless of enable or load that cycle.
REQ-022 SHALL therefore present seg=1000000 (digit 0 showing '0') in the first cycle after reset release.
REQ-023 SHALL discard a pending, untransferred load when reset is applied mid-frame.

Verification (CLK_DIV=4)
REQ-024 Reset 3 cycles, enable=1 -> tick pulses every 4th cycle; counter sequence 0,1,...,7,0; seg=1000000 throughout with active=0.
REQ-025 load=1 value=0x89ABCDEF while counter=3 -> seg unchanged until 7->0 wrap; then digit0=0001110 (F), digit7=0000000 (8).
REQ-026 value=0x0000001A, blank_lz=1 -> digits 0,1 show A (0001000) and 1 (1111001); digits 2-7 show 1111111; blank_lz=0 -> digits 2-7 show 1000000.
REQ-027 load 0x11111111 pending, then load 0x22222222 exactly on the wrap cycle -> frame shows 1s, next frame shows 2s.
REQ-028 enable=0 for 10 cycles mid-frame -> counter, prescaler and tick hold; load accepted; resumes from held count when enable=1.
REQ-029 rst_n=0 with pending load at counter=5 -> counter=0, seg=1000000 next cycle; no transfer at next wrap.

Source files
------------

// File: rtl/ss_scan_driver.sv
// Eight-digit multiplexed seven-segment scan driver.
// A prescaler paces the digit index; displayed data is double-buffered so a
// new value only reaches the display at a frame boundary (7 -> 0 wrap).
module ss_scan_driver #(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] value,
    input  logic        load,
    input  logic        blank_lz,
    output logic [2:0]  counter,
    output logic [6:0]  seg,
    output logic        tick
);

    localparam logic [19:0] PRESC_MAX = 20'(CLK_DIV - 1);

    logic [19:0] prescaler;
    logic [31:0] shadow;
    logic [31:0] active;
    logic        pending;
    logic        blank_q;
    logic [3:0]  nibble;
    logic [2:0]  msd;

    // Hex glyph table, cathodes {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] hex_glyph(input logic [3:0] h);
        logic [6:0] g;
        case (h)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Index of the most significant non-zero nibble; 0 when the word is 0,
    // so digit 0 is never treated as a leading zero.
    function automatic logic [2:0] msd_index(input logic [31:0] v);
        logic [2:0] m;
        m = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (v[k*4 +: 4] != 4'd0) m = 3'(k);
        end
        return m;
    endfunction

    // Prescaler, digit index, tick pulse and the shadow/active data buffers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler <= 20'd0;
            counter   <= 3'd0;
            tick      <= 1'b0;
            shadow    <= 32'd0;
            active    <= 32'd0;
            pending   <= 1'b0;
            blank_q   <= 1'b0;
        end else begin
            tick    <= 1'b0;
            blank_q <= blank_lz;
            if (enable) begin
                if (prescaler == PRESC_MAX) begin
                    prescaler <= 20'd0;
                    tick      <= 1'b1;
                    counter   <= counter + 3'd1;
                    // Frame boundary: the only point where displayed data may change.
                    if (counter == 3'd7 && pending) begin
                        active  <= shadow;
                        pending <= 1'b0;
                    end
                end else begin
                    prescaler <= prescaler + 20'd1;
                end
            end
            // A load in the wrap cycle still lands in shadow and re-arms pending,
            // while active takes the previous shadow contents.
            if (load) begin
                shadow  <= value;
                pending <= 1'b1;
            end
        end
    end

    // Segment decode from registered state only (blank_lz is registered too).
    always_comb begin
        nibble = active[{counter, 2'b00} +: 4];
        msd    = msd_index(active);
        if (blank_q && (counter > msd)) seg = 7'b1111111;
        else                            seg = hex_glyph(nibble);
    end

endmodule

// File: tb/tb_ss_scan_driver.sv
// Directed bench for ss_scan_driver with CLK_DIV=4 (one digit every 4 cycles,
// one frame every 32 cycles). Inputs change and outputs are sampled on the
// falling edge; the design updates on the rising edge.
module tb_ss_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] value;
    logic        load;
    logic        blank_lz;
    logic [2:0]  counter;
    logic [6:0]  seg;
    logic        tick;

    int passed = 0;
    int total  = 0;

    ss_scan_driver #(.CLK_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .value    (value),
        .load     (load),
        .blank_lz (blank_lz),
        .counter  (counter),
        .seg      (seg),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset with enable and load active: everything must clear regardless.
    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; load = 1'b1; value = 32'h12345678;
        cycles(3);
        rst_n = 1'b1; load = 1'b0;
        total++;
        if (counter !== 3'd0) $display("FAIL reset_counter got %0d want 0", counter);
        else passed++;
        total++;
        if (tick !== 1'b0) $display("FAIL reset_tick got %b want 0", tick);
        else passed++;
        total++;
        if (seg !== 7'b1000000) $display("FAIL reset_seg got %b want 1000000", seg);
        else passed++;
    endtask

    // One full frame: tick every 4th cycle, counter 0..7,0, seg shows '0'.
    task automatic test_scan();
        for (int i = 1; i <= 32; i++) begin
            cycles(1);
            total++;
            if (tick !== ((i % 4) == 0)) $display("FAIL scan_tick cyc %0d got %b want %b", i, tick, (i % 4) == 0);
            else passed++;
            total++;
            if (counter !== 3'((i / 4) % 8)) $display("FAIL scan_counter cyc %0d got %0d want %0d", i, counter, (i / 4) % 8);
            else passed++;
            total++;
            if (seg !== 7'b1000000) $display("FAIL scan_seg cyc %0d got %b want 1000000", i, seg);
            else passed++;
        end
    endtask

    // Mid-frame load stays invisible until the wrap, then all eight glyphs.
    task automatic test_load();
        logic [6:0] exp [8] = '{7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
                                7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000};
        cycles(12);
        total++;
        if (counter !== 3'd3) $display("FAIL load_pos got %0d want 3", counter);
        else passed++;
        load = 1'b1; value = 32'h89ABCDEF;
        cycles(1);
        load = 1'b0;
        total++;
        if (seg !== 7'b1000000) $display("FAIL load_nochange_d3 got %b want 1000000", seg);
        else passed++;
        cycles(15);
        total++;
        if (counter !== 3'd7) $display("FAIL load_pos7 got %0d want 7", counter);
        else passed++;
        total++;
        if (seg !== 7'b1000000) $display("FAIL load_nochange_d7 got %b want 1000000", seg);
        else passed++;
        cycles(4);
        for (int d = 0; d < 8; d++) begin
            cycles(2);
            total++;
            if (counter !== 3'(d) || seg !== exp[d])
                $display("FAIL load_digit%0d got ctr %0d seg %b want ctr %0d seg %b", d, counter, seg, d, exp[d]);
            else passed++;
            cycles(2);
        end
    endtask

    // Leading-zero blanking on and off for 0x0000001A.
    task automatic test_blank();
        logic [6:0] exp_on  [8] = '{7'b0001000, 7'b1111001, 7'b1111111, 7'b1111111,
                                    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
        logic [6:0] exp_off [8] = '{7'b0001000, 7'b1111001, 7'b1000000, 7'b1000000,
                                    7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
        load = 1'b1; value = 32'h0000001A;
        cycles(1);
        load = 1'b0;
        cycles(31);
        blank_lz = 1'b1;
        for (int d = 0; d < 8; d++) begin
            cycles(2);
            total++;
            if (counter !== 3'(d) || seg !== exp_on[d])
                $display("FAIL blank_on_digit%0d got ctr %0d seg %b want ctr %0d seg %b", d, counter, seg, d, exp_on[d]);
            else passed++;
            cycles(2);
        end
        blank_lz = 1'b0;
        for (int d = 0; d < 8; d++) begin
            cycles(2);
            total++;
            if (counter !== 3'(d) || seg !== exp_off[d])
                $display("FAIL blank_off_digit%0d got ctr %0d seg %b want ctr %0d seg %b", d, counter, seg, d, exp_off[d]);
            else passed++;
            cycles(2);
        end
    endtask

    // Pending load, then a second load exactly on the wrap cycle.
    task automatic test_back_to_back();
        load = 1'b1; value = 32'h11111111;
        cycles(1);
        load = 1'b0;
        cycles(30);
        total++;
        if (counter !== 3'd7) $display("FAIL b2b_pos got %0d want 7", counter);
        else passed++;
        load = 1'b1; value = 32'h22222222;
        cycles(1);
        load = 1'b0;
        total++;
        if (counter !== 3'd0 || seg !== 7'b1111001) $display("FAIL b2b_frame1_d0 got ctr %0d seg %b want ctr 0 seg 1111001", counter, seg);
        else passed++;
        cycles(16);
        total++;
        if (counter !== 3'd4 || seg !== 7'b1111001) $display("FAIL b2b_frame1_d4 got ctr %0d seg %b want ctr 4 seg 1111001", counter, seg);
        else passed++;
        cycles(16);
        total++;
        if (counter !== 3'd0 || seg !== 7'b0100100) $display("FAIL b2b_frame2_d0 got ctr %0d seg %b want ctr 0 seg 0100100", counter, seg);
        else passed++;
        cycles(20);
        total++;
        if (counter !== 3'd5 || seg !== 7'b0100100) $display("FAIL b2b_frame2_d5 got ctr %0d seg %b want ctr 5 seg 0100100", counter, seg);
        else passed++;
        cycles(12);
    endtask

    // Enable low for 10 cycles mid-digit with a load accepted meanwhile.
    task automatic test_hold();
        logic [6:0] exp [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
        cycles(6);
        enable = 1'b0;
        load = 1'b1; value = 32'h76543210;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            load = 1'b0;
            total++;
            if (counter !== 3'd1 || tick !== 1'b0)
                $display("FAIL hold_cyc%0d got ctr %0d tick %b want ctr 1 tick 0", i, counter, tick);
            else passed++;
        end
        enable = 1'b1;
        cycles(1);
        total++;
        if (counter !== 3'd1 || tick !== 1'b0) $display("FAIL hold_resume1 got ctr %0d tick %b want ctr 1 tick 0", counter, tick);
        else passed++;
        cycles(1);
        total++;
        if (counter !== 3'd2 || tick !== 1'b1) $display("FAIL hold_resume2 got ctr %0d tick %b want ctr 2 tick 1", counter, tick);
        else passed++;
        total++;
        if (seg !== 7'b0100100) $display("FAIL hold_nochange got %b want 0100100", seg);
        else passed++;
        cycles(24);
        for (int d = 0; d < 8; d++) begin
            cycles(2);
            total++;
            if (counter !== 3'(d) || seg !== exp[d])
                $display("FAIL hold_digit%0d got ctr %0d seg %b want ctr %0d seg %b", d, counter, seg, d, exp[d]);
            else passed++;
            cycles(2);
        end
    endtask

    // Reset at counter 5 with a pending load: load is discarded.
    task automatic test_reset_pending();
        load = 1'b1; value = 32'hFFFFFFFF;
        cycles(1);
        load = 1'b0;
        cycles(19);
        total++;
        if (counter !== 3'd5 || seg !== 7'b0010010) $display("FAIL rstp_pre got ctr %0d seg %b want ctr 5 seg 0010010", counter, seg);
        else passed++;
        rst_n = 1'b0; load = 1'b1; value = 32'hEEEEEEEE;
        cycles(1);
        rst_n = 1'b1; load = 1'b0;
        total++;
        if (counter !== 3'd0 || seg !== 7'b1000000 || tick !== 1'b0)
            $display("FAIL rstp_after got ctr %0d seg %b tick %b want ctr 0 seg 1000000 tick 0", counter, seg, tick);
        else passed++;
        cycles(28);
        total++;
        if (counter !== 3'd7 || seg !== 7'b1000000) $display("FAIL rstp_d7 got ctr %0d seg %b want ctr 7 seg 1000000", counter, seg);
        else passed++;
        cycles(4);
        total++;
        if (counter !== 3'd0 || seg !== 7'b1000000) $display("FAIL rstp_nowrap got ctr %0d seg %b want ctr 0 seg 1000000", counter, seg);
        else passed++;
        cycles(8);
        total++;
        if (counter !== 3'd2 || seg !== 7'b1000000) $display("FAIL rstp_d2 got ctr %0d seg %b want ctr 2 seg 1000000", counter, seg);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; value = 32'd0; load = 1'b0; blank_lz = 1'b0;
        cycles(1);
        test_reset();
        test_scan();
        test_load();
        test_blank();
        test_back_to_back();
        test_hold();
        test_reset_pending();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
